// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Holds the FSM state encoding, the display data width and the index-width helper.
package disp_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Request/display bundle between the requesters, the arbiter and the display mux.
// The master side drives requests and clear; the slave side is the arbiter.
interface seg_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import disp_arb_pkg::*;

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      clear;
    logic [DATA_W-1:0]         disp_value;
    logic [IDX_W-1:0]          disp_src;
    logic                      disp_blank;
    logic                      busy;

    modport master (
        output req_valid, req_data, clear,
        input  req_ready, disp_value, disp_src, disp_blank, busy
    );

    modport slave (
        input  req_valid, req_data, clear,
        output req_ready, disp_value, disp_src, disp_blank, busy
    );

endinterface

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_start,
// wrapping modulo NUM_REQ, returned both one-hot and as a binary index.
module rr_pick
    import disp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_start,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any_valid
);

    int               w_pos;
    logic [IDX_W-1:0] w_pos_idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        o_grant     = '0;
        o_idx       = '0;
        o_any_valid = 1'b0;
        w_pos       = 0;
        w_pos_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_pos_idx = IDX_W'(w_pos);
            if (!o_any_valid && i_valid[w_pos_idx]) begin
                o_any_valid          = 1'b1;
                o_grant[w_pos_idx]   = 1'b1;
                o_idx                = w_pos_idx;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the two-digit display between NUM_REQ requesters in round-robin order,
// holding each accepted value for at least HOLD_CYCLES cycles.
module seg_display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t              r_state;
    logic [DATA_W-1:0]   r_disp_value;
    logic [IDX_W-1:0]    r_disp_src;
    logic                r_disp_blank;
    logic                r_busy;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_any_valid;
    logic                w_arb_en;
    logic [IDX_W-1:0]    w_next_ptr;
    logic [DATA_W-1:0]   w_sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_valid     (bus.req_valid),
        .i_start     (r_rr_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_grant_idx),
        .o_any_valid (w_any_valid)
    );

    // Grants only exist in IDLE, and never while clear or reset is asserted.
    assign w_arb_en      = (r_state == IDLE) && !bus.clear && !rst;
    assign bus.req_ready = w_arb_en ? w_grant : '0;

    assign w_next_ptr = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_sel_data = bus.req_data[w_grant_idx*DATA_W +: DATA_W];

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_disp_value <= '0;
            r_disp_src   <= '0;
            r_disp_blank <= 1'b1;
            r_busy       <= 1'b0;
            r_rr_ptr     <= '0;
            r_hold_cnt   <= '0;
        end else if (bus.clear) begin
            r_state      <= IDLE;
            r_disp_blank <= 1'b1;
            r_busy       <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_disp_value <= w_sel_data;
                        r_disp_src   <= w_grant_idx;
                        r_disp_blank <= 1'b0;
                        r_busy       <= 1'b1;
                        r_rr_ptr     <= w_next_ptr;
                        r_hold_cnt   <= HOLD_W'(HOLD_CYCLES - 1);
                        r_state      <= SHOW;
                    end
                end
                SHOW: begin
                    if (r_hold_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_value = r_disp_value;
    assign bus.disp_src   = r_disp_src;
    assign bus.disp_blank = r_disp_blank;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_seg_display_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int HOLD_CYCLES = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seg_display_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    seg_display_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake with the expected winner, then walk the four SHOW cycles back to IDLE.
    task automatic do_grant(input string tag, input logic [3:0] exp_rdy,
                            input logic [7:0] exp_val, input logic [1:0] exp_src);
        #1;
        check({tag, "_rdy"}, 32'(bus.req_ready), 32'(exp_rdy));
        tick();
        check({tag, "_val"},   32'(bus.disp_value), 32'(exp_val));
        check({tag, "_src"},   32'(bus.disp_src),   32'(exp_src));
        check({tag, "_blank"}, 32'(bus.disp_blank), 32'd0);
        repeat (HOLD_CYCLES) begin
            check({tag, "_busy"},   32'(bus.busy),      32'd1);
            check({tag, "_norrdy"}, 32'(bus.req_ready), 32'd0);
            tick();
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.clear     = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_rdy",   32'(bus.req_ready),  32'd0);
        check("rst_blank", 32'(bus.disp_blank), 32'd1);
        check("rst_val",   32'(bus.disp_value), 32'd0);
        check("rst_src",   32'(bus.disp_src),   32'd0);
        check("rst_busy",  32'(bus.busy),       32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check("rel_blank", 32'(bus.disp_blank), 32'd1);
        check("rel_val",   32'(bus.disp_value), 32'd0);
        check("rel_busy",  32'(bus.busy),       32'd0);
        check("rel_rdy",   32'(bus.req_ready),  32'd0);

        // Single grant of requester 2
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'd0, 8'd42, 8'd0, 8'd0};
        #1;
        check("single_rdy", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        check("single_val",   32'(bus.disp_value), 32'd42);
        check("single_src",   32'(bus.disp_src),   32'd2);
        check("single_blank", 32'(bus.disp_blank), 32'd0);
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            check("single_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        check("single_idle",  32'(bus.busy),       32'd0);
        check("single_keep",  32'(bus.disp_value), 32'd42);
        check("single_kblnk", 32'(bus.disp_blank), 32'd0);

        // Asynchronous reset in the middle of SHOW
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'd0, 8'd0, 8'd0, 8'd7};
        tick();
        check("pre_rst_val", 32'(bus.disp_value), 32'd7);
        bus.req_valid = 4'b0010;
        #2;
        rst = 1'b1;
        #1;
        check("async_blank", 32'(bus.disp_blank), 32'd1);
        check("async_val",   32'(bus.disp_value), 32'd0);
        check("async_rdy",   32'(bus.req_ready),  32'd0);
        check("async_busy",  32'(bus.busy),       32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();
        check("async_rel_blank", 32'(bus.disp_blank), 32'd1);
        check("async_rel_val",   32'(bus.disp_value), 32'd0);
        check("async_rel_busy",  32'(bus.busy),       32'd0);

        // Round robin with all four requesters valid, handshakes five cycles apart
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
        do_grant("rr0", 4'b0001, 8'd10, 2'd0);
        do_grant("rr1", 4'b0010, 8'd20, 2'd1);
        do_grant("rr2", 4'b0100, 8'd30, 2'd2);
        do_grant("rr3", 4'b1000, 8'd40, 2'd3);
        do_grant("rr4", 4'b0001, 8'd10, 2'd0);

        // Pointer wrap: grant 3, then only 1 and 3 valid
        bus.req_valid = 4'b1000;
        do_grant("wrap3", 4'b1000, 8'd40, 2'd3);
        bus.req_valid = 4'b1010;
        do_grant("wrap1", 4'b0010, 8'd20, 2'd1);
        do_grant("wrap3b", 4'b1000, 8'd40, 2'd3);

        // clear during the second SHOW cycle with requester 0 valid
        bus.req_valid = 4'b0001;
        #1;
        check("clr_pre_rdy", 32'(bus.req_ready), 32'b0001);
        tick();
        check("clr_show_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.clear = 1'b1;
        #1;
        check("clr_rdy", 32'(bus.req_ready), 32'd0);
        tick();
        bus.clear = 1'b0;
        check("clr_blank", 32'(bus.disp_blank), 32'd1);
        check("clr_busy",  32'(bus.busy),       32'd0);
        check("clr_val",   32'(bus.disp_value), 32'd10);
        check("clr_src",   32'(bus.disp_src),   32'd0);
        #1;
        check("clr_regrant_rdy", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = '0;
        check("clr_regrant_val",   32'(bus.disp_value), 32'd10);
        check("clr_regrant_blank", 32'(bus.disp_blank), 32'd0);
        check("clr_regrant_busy",  32'(bus.busy),       32'd1);
        repeat (HOLD_CYCLES) tick();
        check("clr_done_busy", 32'(bus.busy), 32'd0);

        // Withdrawn request during SHOW; data changes after the handshake are ignored
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'd40, 8'd30, 8'd20, 8'd55};
        #1;
        check("wd_rdy0", 32'(bus.req_ready), 32'b0001);
        tick();
        check("wd_val", 32'(bus.disp_value), 32'd55);
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'd40, 8'd33, 8'd20, 8'd99};
        repeat (2) begin
            #1;
            check("wd_show_rdy", 32'(bus.req_ready), 32'd0);
            tick();
        end
        check("wd_sample_val", 32'(bus.disp_value), 32'd55);
        bus.req_valid = '0;
        #1;
        check("wd_drop_rdy", 32'(bus.req_ready), 32'd0);
        repeat (2) tick();
        check("wd_idle_busy", 32'(bus.busy),       32'd0);
        check("wd_idle_rdy",  32'(bus.req_ready),  32'd0);
        check("wd_idle_val",  32'(bus.disp_value), 32'd55);
        check("wd_idle_src",  32'(bus.disp_src),   32'd0);
        tick();
        check("wd_late_rdy", 32'(bus.req_ready),  32'd0);
        check("wd_late_val", 32'(bus.disp_value), 32'd55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
